// File: rtl/des_byte_framer.sv
// rtl/des_byte_framer.sv - byte-to-block framer around a DES decrypt core
// Optional block counter enabled by defining DES_FRAMER_BLKCNT_EN.
module des_byte_framer #(
  parameter int unsigned CORE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_we,
  input  logic [63:0] key_in,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic [63:0] core_in,
  output logic [63:0] core_key,
  input  logic [63:0] core_out,
`ifdef DES_FRAMER_BLKCNT_EN
  output logic [15:0] blk_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

  state_t      state, state_nx;
  logic [2:0]  byte_cnt;
  logic [3:0]  wait_cnt;
  logic [63:0] sreg;
  logic        in_fire, out_fire, wait_done;

  // Handshake outputs are forced low while reset is held, even before the
  // state register has returned to FILL.
  assign in_ready  = (state == FILL) && !rst;
  assign out_valid = (state == DRAIN) && !rst;
  assign busy      = !rst && ((state != FILL) || (byte_cnt != 3'd0));
  assign out_data  = sreg[63:56];

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wait_done = (state == WAIT) && (wait_cnt == 4'(CORE_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL:    if (in_fire && byte_cnt == 3'd7)  state_nx = WAIT;
      WAIT:    if (wait_done)                    state_nx = DRAIN;
      DRAIN:   if (out_fire && byte_cnt == 3'd7) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  // byte_cnt counts accepted bytes in FILL and sent bytes in DRAIN; both
  // phases end on a wrap to 0, which is what FILL expects on re-entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 3'd0;
      wait_cnt <= 4'd0;
      core_in  <= 64'd0;
      core_key <= 64'd0;
      sreg     <= 64'd0;
    end else begin
      if (in_fire) begin
        core_in[{~byte_cnt, 3'b000} +: 8] <= in_data;
        byte_cnt <= byte_cnt + 3'd1;
      end
      if (out_fire) begin
        sreg     <= {sreg[55:0], 8'h00};
        byte_cnt <= byte_cnt + 3'd1;
      end
      if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
      else               wait_cnt <= 4'd0;
      if (wait_done) sreg <= core_out;
      if (key_we && state == FILL && byte_cnt == 3'd0) core_key <= key_in;
    end
  end

`ifdef DES_FRAMER_BLKCNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                       blk_cnt <= 16'd0;
    else if (out_fire && byte_cnt == 3'd7)         blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_des_byte_framer.sv
// tb/tb_des_byte_framer.sv - scoreboard bench for des_byte_framer
// Decrypt core is a stub: the DES known-answer pair plus a keyed swap elsewhere.
module tb_des_byte_framer;

  localparam int LAT = 3;
  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;

  logic        clk = 1'b0;
  logic        rst, key_we, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] key_in, core_in, core_key, core_out;
  logic [7:0]  in_data, out_data;
`ifdef DES_FRAMER_BLKCNT_EN
  logic [15:0] blk_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  logic [63:0] model_key;

  always #5 clk = ~clk;

  function automatic logic [63:0] core_model(input logic [63:0] ct, input logic [63:0] k);
    if (ct == KAT_CT && k == KAT_KEY) return KAT_PT;
    return {ct[31:0], ct[63:32]} ^ k;
  endfunction

  assign core_out = core_model(core_in, core_key);

  des_byte_framer #(.CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .key_we(key_we), .key_in(key_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_in(core_in), .core_key(core_key), .core_out(core_out),
`ifdef DES_FRAMER_BLKCNT_EN
    .blk_cnt(blk_cnt),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bytes(input logic [63:0] blk, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_data  = blk[63-8*i -: 8];
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      @(negedge clk);
      key_we = 1'b0;
    end
    in_valid = 1'b0;
    if (last == 7) begin
      logic [63:0] pt = core_model(blk, model_key);
      for (int b = 0; b < 8; b++) sb.push_back(pt[63-8*b -: 8]);
    end
  endtask

  task automatic wait_out();
    int guard = 0;
    while (!out_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  task automatic recv_bytes(input int n, input bit stall);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 500) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        check("out_data", 64'(out_data), (sb.size() > 0) ? 64'(sb[0]) : 64'hx);
        if (out_ready) begin
          void'(sb.pop_front());
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("recv_count", 64'(got), 64'(n));
    if (!stall) check("drain_cycles", 64'(cyc), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; key_we = 1'b0; key_in = 64'd0; in_valid = 1'b0;
    in_data = 8'd0; out_ready = 1'b0; model_key = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_core_in",   core_in,        64'd0);
    check("rst_core_key",  core_key,       64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
`ifdef DES_FRAMER_BLKCNT_EN
    check("rst_blk_cnt",   64'(blk_cnt),   64'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_busy",     64'(busy),     64'd0);

    // Known-answer block, key written together with the first byte
    key_in = KAT_KEY; key_we = 1'b1; model_key = KAT_KEY;
    send_bytes(KAT_CT, 0, 0);
    check("key_with_first_byte", core_key, KAT_KEY);
    check("busy_one_byte", 64'(busy), 64'd1);
    send_bytes(KAT_CT, 1, 7);
    for (int c = 0; c < LAT; c++) begin
      check("wait_out_valid", 64'(out_valid), 64'd0);
      check("wait_in_ready",  64'(in_ready),  64'd0);
      check("wait_core_in",   core_in,        KAT_CT);
      @(negedge clk);
    end
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_byte",  64'(out_data),  64'h01);
    recv_bytes(8, 1'b0);
    check("turn_in_ready",  64'(in_ready),  64'd1);
    check("turn_out_valid", 64'(out_valid), 64'd0);
    check("turn_busy",      64'(busy),      64'd0);

    // Backpressure in DRAIN
    send_bytes(KAT_CT, 0, 7);
    wait_out();
    repeat (5) begin
      check("bp_out_data", 64'(out_data), 64'h01);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    recv_bytes(8, 1'b0);

    // Key lock mid-block, then accepted at counter 0
    send_bytes(64'h0011223344556677, 0, 2);
    key_in = 64'hFFFFFFFFFFFFFFFF; key_we = 1'b1;
    @(negedge clk);
    key_we = 1'b0;
    check("key_locked", core_key, KAT_KEY);
    check("busy_partial", 64'(busy), 64'd1);
    send_bytes(64'h0011223344556677, 3, 7);
    wait_out();
    recv_bytes(8, 1'b0);
    key_we = 1'b1;
    @(negedge clk);
    key_we = 1'b0;
    model_key = 64'hFFFFFFFFFFFFFFFF;
    check("key_unlocked", core_key, 64'hFFFFFFFFFFFFFFFF);

    // Random blocks and keys with random downstream stalls
    for (int r = 0; r < 3; r++) begin
      logic [63:0] blk = {$urandom, $urandom};
      key_in = {$urandom, $urandom}; key_we = 1'b1; model_key = key_in;
      send_bytes(blk, 0, 7);
      wait_out();
      recv_bytes(8, 1'b1);
    end

    // Reset in the middle of WAIT
    send_bytes(64'hA5A5_5A5A_F00D_BEEF, 0, 7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_core_in",   core_in,        64'd0);
    check("mid_rst_core_key",  core_key,       64'd0);
    check("mid_rst_out_data",  64'(out_data),  64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", 64'(in_ready), 64'd1);
    key_in = KAT_KEY; key_we = 1'b1; model_key = KAT_KEY;
    send_bytes(KAT_CT, 0, 7);
    wait_out();
    recv_bytes(8, 1'b0);

`ifdef DES_FRAMER_BLKCNT_EN
    force dut.blk_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt;
    send_bytes(KAT_CT, 0, 7);
    wait_out();
    recv_bytes(8, 1'b0);
    check("blk_cnt_wrap", 64'(blk_cnt), 64'd0);
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
